// File: rtl/deserializador_sincrono_if.sv
// Serial-in / word-out handshake bundle for deserializador_sincrono.
// o_parity_err exists only when DESER_PARITY_EN is defined.
interface deserializador_sincrono_if #(
    parameter int WIDTH = 4
);
    localparam int IDX_W = $clog2(WIDTH);

    logic             i_serial;
    logic             i_valid;
    logic             i_clr;
    logic             i_ready;
    logic [WIDTH-1:0] o_data;
    logic             o_valid;
    logic [IDX_W-1:0] o_index;
    logic             o_busy;
    logic             o_overrun;
`ifdef DESER_PARITY_EN
    logic             o_parity_err;
`endif

    modport slave (
        input  i_serial,
        input  i_valid,
        input  i_clr,
        input  i_ready,
        output o_data,
        output o_valid,
        output o_index,
        output o_busy,
`ifdef DESER_PARITY_EN
        output o_parity_err,
`endif
        output o_overrun
    );

    modport master (
        output i_serial,
        output i_valid,
        output i_clr,
        output i_ready,
        input  o_data,
        input  o_valid,
        input  o_index,
        input  o_busy,
`ifdef DESER_PARITY_EN
        input  o_parity_err,
`endif
        input  o_overrun
    );
endinterface

// File: rtl/deserializador_sincrono.sv
// LSB-first serial-to-parallel converter with valid/ready output and sticky overrun.
// Define DESER_PARITY_EN to append one even-parity bit per word (adds state PAR and o_parity_err).
module deserializador_sincrono #(
    parameter int WIDTH = 4
) (
    input logic                     i_clk,
    input logic                     i_rst_n,
    deserializador_sincrono_if.slave bus
);
    localparam int               IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

`ifdef DESER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, PAR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             complete;
    logic [WIDTH-1:0] word;
`ifdef DESER_PARITY_EN
    logic             parity_err_q, parity_err_d;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            index_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
`ifdef DESER_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            index_q   <= index_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
`ifdef DESER_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Bits shift in from the top, so after WIDTH shifts the first bit sits at bit 0.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        index_d   = index_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        complete  = 1'b0;
        word      = shift_q;
`ifdef DESER_PARITY_EN
        parity_err_d = parity_err_q;
`endif

        if (valid_q && bus.i_ready) begin
            valid_d = 1'b0;
        end

        if (bus.i_clr) begin
            state_d   = IDLE;
            index_d   = '0;
            overrun_d = 1'b0;
        end else if (bus.i_valid) begin
            case (state_q)
                IDLE: begin
                    shift_d = {bus.i_serial, shift_q[WIDTH-1:1]};
                    index_d = ONE_IDX;
                    state_d = RECV;
                end
                RECV: begin
                    shift_d = {bus.i_serial, shift_q[WIDTH-1:1]};
                    if (index_q == LAST_IDX) begin
                        index_d = '0;
`ifdef DESER_PARITY_EN
                        state_d = PAR;
`else
                        state_d  = IDLE;
                        complete = 1'b1;
                        word     = {bus.i_serial, shift_q[WIDTH-1:1]};
`endif
                    end else begin
                        index_d = index_q + ONE_IDX;
                    end
                end
`ifdef DESER_PARITY_EN
                PAR: begin
                    state_d      = IDLE;
                    complete     = 1'b1;
                    word         = shift_q;
                    parity_err_d = ^{shift_q, bus.i_serial};
                end
`endif
                default: state_d = IDLE;
            endcase
        end

        // A handshake on the completing edge frees the slot, so no overrun then.
        if (complete) begin
            data_d  = word;
            valid_d = 1'b1;
            if (valid_q && !bus.i_ready) begin
                overrun_d = 1'b1;
            end
        end
    end

    assign bus.o_data    = data_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_index   = index_q;
    assign bus.o_busy    = (state_q != IDLE);
    assign bus.o_overrun = overrun_q;
`ifdef DESER_PARITY_EN
    assign bus.o_parity_err = parity_err_q;
`endif
endmodule

// File: tb/tb_deserializador_sincrono.sv
// Directed plus random bench for deserializador_sincrono (WIDTH=4) against a bit-counting reference model.
// Works in both builds; the parity scenario is compiled only with DESER_PARITY_EN.
module tb_deserializador_sincrono;
    localparam int WIDTH = 4;
`ifdef DESER_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif

    logic clk;
    logic rst_n;
    int   vectors;
    int   errors;

    // Reference model: bits of the current word collected so far, plus output registers.
    int               mCount;
    logic [WIDTH-1:0] mBits;
    logic             mParAcc;
    logic [WIDTH-1:0] mData;
    logic             mValid;
    logic             mOverrun;
    logic             mParErr;

    deserializador_sincrono_if #(.WIDTH(WIDTH)) dut_if ();

    deserializador_sincrono #(.WIDTH(WIDTH)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [15:0] expIdx;
        expIdx = (mCount < WIDTH) ? 16'(mCount) : 16'd0;
        checkVal({tag, ".data"},    16'(dut_if.o_data),    16'(mData));
        checkVal({tag, ".valid"},   16'(dut_if.o_valid),   16'(mValid));
        checkVal({tag, ".index"},   16'(dut_if.o_index),   expIdx);
        checkVal({tag, ".busy"},    16'(dut_if.o_busy),    16'(mCount != 0));
        checkVal({tag, ".overrun"}, 16'(dut_if.o_overrun), 16'(mOverrun));
`ifdef DESER_PARITY_EN
        checkVal({tag, ".parerr"},  16'(dut_if.o_parity_err), 16'(mParErr));
`endif
    endtask

    task automatic modelReset();
        mCount   = 0;
        mBits    = '0;
        mParAcc  = 1'b0;
        mData    = '0;
        mValid   = 1'b0;
        mOverrun = 1'b0;
        mParErr  = 1'b0;
    endtask

    task automatic modelUpdate(input logic serial, input logic valid, input logic clr, input logic ready);
        logic prevValid;
        prevValid = mValid;
        if (mValid && ready) mValid = 1'b0;
        if (clr) begin
            mCount   = 0;
            mOverrun = 1'b0;
        end else if (valid) begin
            if (mCount < WIDTH) mBits[mCount] = serial;
            mParAcc = (mCount == 0) ? serial : (mParAcc ^ serial);
            mCount++;
            if (mCount == NB) begin
                if (prevValid && !ready) mOverrun = 1'b1;
                mData   = mBits;
                mValid  = 1'b1;
                mParErr = mParAcc;
                mCount  = 0;
            end
        end
    endtask

    // One clock: drive on the falling edge, check 1 time unit after the rising edge.
    task automatic applyStimulus(input logic serial, input logic valid, input logic clr, input logic ready,
                                 input string tag);
        @(negedge clk);
        dut_if.i_serial = serial;
        dut_if.i_valid  = valid;
        dut_if.i_clr    = clr;
        dut_if.i_ready  = ready;
        modelUpdate(serial, valid, clr, ready);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic sendWord(input logic [WIDTH-1:0] w, input logic rdyBody, input logic rdyLast, input string tag);
        for (int k = 0; k < WIDTH; k++) begin
`ifdef DESER_PARITY_EN
            applyStimulus(w[k], 1'b1, 1'b0, rdyBody, tag);
`else
            applyStimulus(w[k], 1'b1, 1'b0, (k == WIDTH - 1) ? rdyLast : rdyBody, tag);
`endif
        end
`ifdef DESER_PARITY_EN
        applyStimulus(^w, 1'b1, 1'b0, rdyLast, tag);
`endif
    endtask

    // Reset asserted between edges; outputs must drop before any clock edge.
    task automatic applyReset(input string tag);
        @(negedge clk);
        dut_if.i_valid = 1'b0;
        dut_if.i_clr   = 1'b0;
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput(tag);
        checkVal({tag, ".data_zero"}, 16'(dut_if.o_data), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        modelReset();
        rst_n           = 1'b0;
        dut_if.i_serial = 1'b0;
        dut_if.i_valid  = 1'b0;
        dut_if.i_clr    = 1'b0;
        dut_if.i_ready  = 1'b0;
        #3;
        checkOutput("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset released");

        // Word 1001 with consumer ready: o_valid lasts exactly one cycle.
        sendWord(4'b1001, 1'b1, 1'b1, "s1");
        checkVal("s1.word", 16'(dut_if.o_data), 16'h9);
        checkVal("s1.valid_hi", 16'(dut_if.o_valid), 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "s1.idle");
        checkVal("s1.valid_lo", 16'(dut_if.o_valid), 16'd0);

        // Bits 1,1 separated by idle gaps, then 0,0; index holds through gaps.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, "s2");
        for (int g = 0; g < 3; g++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "s2.gap");
            checkVal("s2.gap_index1", 16'(dut_if.o_index), 16'd1);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, "s2");
        for (int g = 0; g < 3; g++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "s2.gap");
            checkVal("s2.gap_index2", 16'(dut_if.o_index), 16'd2);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, "s2");
`ifdef DESER_PARITY_EN
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, "s2");
`endif
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, "s2");
        checkVal("s2.word", 16'(dut_if.o_data), 16'h3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "s2.drain");

        // Back-to-back words with consumer stalled: overwrite and overrun.
        sendWord(4'b1001, 1'b0, 1'b0, "s3a");
        sendWord(4'b0110, 1'b0, 1'b0, "s3b");
        checkVal("s3.word", 16'(dut_if.o_data), 16'h6);
        checkVal("s3.valid", 16'(dut_if.o_valid), 16'd1);
        checkVal("s3.overrun", 16'(dut_if.o_overrun), 16'd1);

        // Clear with a simultaneous bit; completion on a handshake edge keeps o_valid without overrun.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "s4");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "s4");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, "s4.clr");
        checkVal("s4.clr_overrun", 16'(dut_if.o_overrun), 16'd0);
        checkVal("s4.clr_valid", 16'(dut_if.o_valid), 16'd1);
        checkVal("s4.clr_index", 16'(dut_if.o_index), 16'd0);
        checkVal("s4.clr_busy", 16'(dut_if.o_busy), 16'd0);
        sendWord(4'b1010, 1'b0, 1'b1, "s4w");
        checkVal("s4.word", 16'(dut_if.o_data), 16'hA);
        checkVal("s4.valid", 16'(dut_if.o_valid), 16'd1);
        checkVal("s4.overrun", 16'(dut_if.o_overrun), 16'd0);

        // Asynchronous reset after three bits, then a fresh word.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, "s5");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, "s5");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, "s5");
        applyReset("s5.rst");
        sendWord(4'b1011, 1'b1, 1'b1, "s5w");
        checkVal("s5.word", 16'(dut_if.o_data), 16'hB);
        checkVal("s5.valid", 16'(dut_if.o_valid), 16'd1);

`ifdef DESER_PARITY_EN
        // Data 1,0,0,1 has even weight: parity bit 1 is an error, 0 is not.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, "s6a");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, "s6a");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, "s6a");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, "s6a");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, "s6a.par");
        checkVal("s6.err_set", 16'(dut_if.o_parity_err), 16'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, "s6b");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, "s6b");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, "s6b");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, "s6b");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, "s6b.par");
        checkVal("s6.err_clr", 16'(dut_if.o_parity_err), 16'd0);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/deserializador_sincrono.md
DESERIALIZADOR_SINCRONO -- requirements
Module: deserializador_sincrono

Interface
REQ-001 Parameter WIDTH, default 4, sets the number of data bits per word; legal range is 2..16.
REQ-002 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 i_serial  input  1  serial data bit, sampled only when i_valid=1.
REQ-005 i_valid  input  1  qualifies i_serial for one clock (one bit per valid cycle).
REQ-006 i_clr  input  1  synchronous abort; discards any partially received word.
REQ-007 i_ready  input  1  consumer accepts o_data when o_valid=1 and i_ready=1.
REQ-008 o_data  output  WIDTH  last completed word.
REQ-009 o_valid  output  1  o_data holds an unaccepted word.
REQ-010 o_index  output  clog2(WIDTH)  index of the next bit to be written into the word.
REQ-011 o_busy  output  1  high while a word is partially received (state not IDLE).
REQ-012 o_overrun  output  1  sticky flag: a completed word overwrote an unaccepted word.

Function
REQ-013 The bit order SHALL be LSB-first: the k-th accepted bit of a word lands in o_data[k].
REQ-014 The FSM SHALL have the states IDLE and RECV, plus PAR when DESER_PARITY_EN is defined.
- IDLE -> RECV on i_valid, capturing bit 0.
- RECV stays in RECV while o_index < WIDTH-1.
REQ-015 In RECV, i_valid at o_index=WIDTH-1 SHALL complete the word.
- The full shift register is loaded into o_data and o_valid is set at that same edge.
- Latency: o_valid is visible 1 cycle after the last bit is sampled.
- The FSM returns to IDLE (or goes to PAR when parity is compiled in).
REQ-016 Cycles with i_valid=0 SHALL leave the state, o_index and the partial word unchanged; there is no timeout.
REQ-017 o_valid SHALL clear on an edge where o_valid=1 and i_ready=1, unless a new word completes at that same edge; in that case o_valid stays 1 with the new data and no overrun is flagged.
REQ-018 A word completing while o_valid=1 and i_ready=0 SHALL overwrite o_data, keep o_valid=1 and set o_overrun.
- o_overrun clears only on reset or i_clr.
REQ-019 A bit arriving in the IDLE cycle right after completion SHALL be accepted as bit 0 of the next word; back-to-back words need no gap cycle.
REQ-020 i_clr SHALL have priority over i_valid: the FSM goes to IDLE and o_index to 0, and o_overrun clears.
- o_data and o_valid are not affected by i_clr.
REQ-021 o_index SHALL wrap to 0 on word completion and never exceed WIDTH-1.

Reset
REQ-022 Asserting i_rst_n=0 SHALL immediately, without waiting for a clock edge, set:
- state to IDLE, shift register to 0, o_data to 0, o_index to 0;
- o_valid, o_busy and o_overrun to 0.
REQ-023 Reset mid-word SHALL discard the partial word.
REQ-024 After release of i_rst_n, the first i_valid SHALL be treated as bit 0.

Configuration
REQ-025 Macro DESER_PARITY_EN SHALL be defined to compile in the parity feature.
REQ-026 With DESER_PARITY_EN defined, each word SHALL be followed by one even-parity bit, taken in state PAR on i_valid.
- o_data and o_valid update at the parity-bit edge, not at the last data-bit edge.
- An extra output o_parity_err (1 bit, reset 0) is set with o_valid when the XOR of the data and parity bits is 1.
- o_parity_err is held with o_data.
REQ-027 Without DESER_PARITY_EN, the PAR state and the o_parity_err port SHALL NOT exist, and words complete on the last data bit.

Verification
REQ-028 The bench SHALL cover the following directed scenarios (WIDTH=4):
- Reset, then bits 1,0,0,1 with i_ready=1 -> o_data=4'b1001 and o_valid high for exactly 1 cycle after the 4th bit.
- Bits 1,1 with i_valid gaps of 3 idle cycles each, then 0,0 -> o_data=4'b0011; o_index holds its value during the gaps.
- Two words 4'b1001 and 4'b0110 back-to-back with i_ready=0 -> o_data=4'b0110, o_valid=1, o_overrun=1.
- 2 bits, then i_clr together with i_valid=1, then bits 0,1,0,1 -> o_data=4'b1010; the cleared bit is ignored.
- i_rst_n=0 asserted between clock edges after 3 bits -> all outputs 0 immediately; the next 4 bits form a fresh word.
- With DESER_PARITY_EN: data 1,0,0,1 + parity 1 -> o_parity_err=1; with parity 0 -> o_parity_err=0.
